// File: rtl/adc_axis_packetizer.sv
// Parallel-ADC capture -> FIFO -> fixed-length AXI4-Stream packets with overrun/OTR status.
// Define ADC_TEST_PATTERN_EN to add the control[4] ramp test-pattern source.
module adc_axis_packetizer #(
  parameter int ADC_BITS    = 14,
  parameter int CLK_DIV     = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int PKT_LEN     = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_areset,
  output logic                     adc_clk_o,
  input  logic [ADC_BITS:0]        adc_data,
  input  logic [7:0]               control,
  output logic [31:0]              status,
  output logic                     m00_axis_tvalid,
  output logic [TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                     m00_axis_tlast,
  input  logic                     m00_axis_tready
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(PKT_LEN);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
  localparam logic [7:0]    DEPTH_L   = 8'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  logic clk, rst;
  assign clk = m00_axis_aclk;
  assign rst = m00_axis_areset;

  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic adc_clk_q, strobe;
  logic en, clr_ovr, clr_otr, twos;
  logic en_q, start;
  logic [ADC_BITS:0] src, cap_q;
  logic cap_vld_q;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [7:0] level_q, level_d;
  logic ovr_q, ovr_d, otr_q, otr_d;
  logic [15:0] cnt_q, cnt_d;
  logic push_try, push_ok, pop, drop, is_last, full, tvalid;
  logic [TDATA_WIDTH-1:0] fmt;
  logic [TDATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [TDATA_WIDTH:0] rd_word;
  logic [ADC_BITS-1:0] smp;
  logic unused_ctrl;

  assign en      = control[0];
  assign clr_ovr = control[1];
  assign clr_otr = control[2];
  assign twos    = control[3];

  assign strobe = (div_q == DIV_LAST);
  assign div_d  = strobe ? '0 : div_q + 1'b1;
  assign start  = (state_q == IDLE) && en && !en_q;

`ifdef ADC_TEST_PATTERN_EN
  logic [ADC_BITS-1:0] ramp_q, ramp_cur;
  assign ramp_cur = start ? '0 : ramp_q;
  assign src = control[4] ? {1'b0, ramp_cur} : adc_data;
  assign unused_ctrl = ^control[7:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= strobe ? ramp_cur + 1'b1 : ramp_cur;
    end
  end
`else
  assign src = adc_data;
  assign unused_ctrl = ^control[7:4];
`endif

  // Two's-complement samples are sign-extended into an (ADC_BITS+2)-bit field.
  assign smp = cap_q[ADC_BITS-1:0];
  always_comb begin
    fmt = '0;
    if (twos) begin
      fmt[ADC_BITS+1:0] = {~smp[ADC_BITS-1], ~smp[ADC_BITS-1],
                           ~smp[ADC_BITS-1], smp[ADC_BITS-2:0]};
    end else begin
      fmt[ADC_BITS-1:0] = smp;
    end
    fmt[TDATA_WIDTH-1] = cap_q[ADC_BITS];
  end

  assign tvalid   = (level_q != 8'd0);
  assign full     = (level_q == DEPTH_L);
  assign pop      = tvalid && m00_axis_tready;
  assign is_last  = (beat_q == BEAT_LAST);
  // An idle stop at a packet boundary must not start a new packet.
  assign push_try = cap_vld_q && (state_q == RUN)
                  && !(beat_q == '0 && !en);
  assign push_ok  = push_try && (!full || pop);
  assign drop     = push_try && !push_ok;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          beat_d  = '0;
        end
      end
      RUN: begin
        if (!en && beat_q == '0) begin
          state_d = DRAIN;
        end else if (push_ok) begin
          beat_d = is_last ? '0 : beat_q + 1'b1;
          if (is_last && !en) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (level_q == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) level_d = level_q + 8'd1;
    else if (!push_ok && pop) level_d = level_q - 8'd1;
    ovr_d = ovr_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovr_d = 1'b1;
      cnt_d = clr_ovr ? 16'd1 : (&cnt_q ? cnt_q : cnt_q + 16'd1);
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end
    otr_d = otr_q;
    if (push_ok && cap_q[ADC_BITS]) otr_d = 1'b1;
    else if (clr_otr) otr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      adc_clk_q <= 1'b0;
      en_q      <= 1'b0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      beat_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      ovr_q     <= 1'b0;
      otr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      adc_clk_q <= (div_d < DIV_HALF);
      en_q      <= en;
      if (strobe) cap_q <= src;
      cap_vld_q <= strobe;
      beat_q    <= beat_d;
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      level_q   <= level_d;
      ovr_q     <= ovr_d;
      otr_q     <= otr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {is_last, fmt};
  end

  assign rd_word = mem_q[rd_q];

  assign adc_clk_o       = adc_clk_q;
  assign m00_axis_tvalid = tvalid;
  assign m00_axis_tdata  = tvalid ? rd_word[TDATA_WIDTH-1:0] : '0;
  assign m00_axis_tlast  = tvalid && rd_word[TDATA_WIDTH];
  assign m00_axis_tstrb  = '1;
  assign status = {cnt_q, level_q, 4'b0000, state_q == DRAIN,
                   otr_q, ovr_q, state_q != IDLE};

endmodule
